// File: rtl/bp_axil_mmio_pkg.sv
// Shared constants and types for the BP MMIO request buffer.
package bp_axil_mmio_pkg;

  localparam logic [11:0] mmio_req_cnt_addr = 12'h8;
  localparam logic [11:0] mmio_req_addr     = 12'hC;

  typedef enum logic [1:0] {
    e_axil_okay   = 2'b00,
    e_axil_slverr = 2'b10,
    e_axil_decerr = 2'b11
  } axil_resp_e;

  typedef enum logic {
    e_reset = 1'b0,
    e_run   = 1'b1
  } state_e;

  typedef enum logic {
    e_w_collect = 1'b0,
    e_w_resp    = 1'b1
  } w_state_e;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read one-write FIFO with a separate occupancy counter, so the
// pointers can wrap freely without full/empty ambiguity.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 64,
  parameter int els_p   = 16,
  localparam int ptr_w_lp = $clog2(els_p),
  localparam int cnt_w_lp = $clog2(els_p) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                v_i,
  input  logic [width_p-1:0]  data_i,
  output logic                ready_o,
  output logic                v_o,
  output logic [width_p-1:0]  data_o,
  input  logic                yumi_i,
  output logic [cnt_w_lp-1:0] count_o
);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] wptr_r, rptr_r;
  logic [cnt_w_lp-1:0] count_r;
  logic                enq, deq;

  assign ready_o = (count_r < cnt_w_lp'(els_p));
  assign v_o     = (count_r != '0);
  assign data_o  = mem_r[rptr_r];
  assign count_o = count_r;
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  // Storage array; contents need no reset since the counter qualifies them.
  always_ff @(posedge clk) begin
    if (enq) mem_r[wptr_r] <= data_i;
  end

  // Pointers and occupancy; simultaneous enqueue and dequeue cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq) wptr_r <= wptr_r + ptr_w_lp'(1);
      if (deq) rptr_r <= rptr_r + ptr_w_lp'(1);
      count_r <= count_r + cnt_w_lp'(enq) - cnt_w_lp'(deq);
    end
  end

endmodule

// File: rtl/bp_axil_mmio_req_buffer.sv
// AXI4-Lite read responder draining buffered BP MMIO (addr, data) pairs.
//
// state       | meaning
// ------------+---------------------------------------------------------
// e_reset     | first cycle after reset release; all handshakes held off
// e_run       | normal operation
// e_w_collect | gathering AW and W beats (each held until the other lands)
// e_w_resp    | SLVERR write response pending on B channel
module bp_axil_mmio_req_buffer
  import bp_axil_mmio_pkg::*;
#(
  parameter int S_AXIL_ADDR_WIDTH = 64,
  parameter int S_AXIL_DATA_WIDTH = 32,
  parameter int els_p             = 32
) (
  input  logic                           s_axil_aclk,
  input  logic                           s_axil_aresetn,

  input  logic                           mmio_v_i,
  input  logic [31:0]                    mmio_addr_i,
  input  logic [31:0]                    mmio_data_i,
  output logic                           mmio_ready_and_o,

  input  logic [S_AXIL_ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic                           s_axil_arvalid,
  output logic                           s_axil_arready,
  input  logic [2:0]                     s_axil_arprot,
  output logic [S_AXIL_DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]                     s_axil_rresp,
  output logic                           s_axil_rvalid,
  input  logic                           s_axil_rready,

  input  logic [S_AXIL_ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic                           s_axil_awvalid,
  output logic                           s_axil_awready,
  input  logic [2:0]                     s_axil_awprot,
  input  logic [S_AXIL_DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [S_AXIL_DATA_WIDTH/8-1:0] s_axil_wstrb,
  input  logic                           s_axil_wvalid,
  output logic                           s_axil_wready,
  output logic [1:0]                     s_axil_bresp,
  output logic                           s_axil_bvalid,
  input  logic                           s_axil_bready
);

  localparam int pair_els_lp   = els_p / 2;
  localparam int pair_cnt_w_lp = $clog2(pair_els_lp) + 1;
  localparam int word_cnt_w_lp = $clog2(els_p) + 1;

  state_e   state_r, state_n;
  w_state_e w_state_r, w_state_n;
  logic     run;

  logic                       fifo_ready, fifo_v, fifo_yumi, push;
  logic [63:0]                fifo_data;
  logic [pair_cnt_w_lp-1:0]   pair_cnt;
  logic [word_cnt_w_lp-1:0]   word_cnt;

  logic                         half_r;
  logic                         rvalid_r;
  logic [S_AXIL_DATA_WIDTH-1:0] rdata_r, rdata_n;
  logic [1:0]                   rresp_r, rresp_n;
  logic                         ar_fire, pop_word, pop_take;

  logic aw_held_r, aw_held_n, w_held_r, w_held_n;
  logic aw_fire, w_fire;

  logic unused_inputs;
  assign unused_inputs = ^{s_axil_araddr, s_axil_arprot, s_axil_awaddr,
                           s_axil_awprot, s_axil_wdata, s_axil_wstrb, fifo_v};

  // Top-level state register.
  always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
    if (!s_axil_aresetn) state_r <= e_reset;
    else                 state_r <= state_n;
  end

  // Leave e_reset on the first clock after reset release.
  always_comb begin
    state_n = state_r;
    if (state_r == e_reset) state_n = e_run;
  end

  assign run = (state_r == e_run);

  // Pair storage; yumi pops a pair only when its data word is read.
  assign mmio_ready_and_o = run & fifo_ready;
  assign push             = mmio_v_i & mmio_ready_and_o;
  assign fifo_yumi        = pop_take & half_r;

  bsg_fifo_1r1w_small #(
    .width_p(64),
    .els_p  (pair_els_lp)
  ) pair_fifo (
    .clk    (s_axil_aclk),
    .rst_n  (s_axil_aresetn),
    .v_i    (push),
    .data_i ({mmio_data_i, mmio_addr_i}),
    .ready_o(fifo_ready),
    .v_o    (fifo_v),
    .data_o (fifo_data),
    .yumi_i (fifo_yumi),
    .count_o(pair_cnt)
  );

  assign word_cnt = {pair_cnt, 1'b0} - word_cnt_w_lp'(half_r);

  assign s_axil_arready = run & (~rvalid_r | s_axil_rready);
  assign ar_fire        = s_axil_arvalid & s_axil_arready;

  // Read address decode; only the low 12 address bits select a register.
  always_comb begin
    rdata_n  = '0;
    rresp_n  = e_axil_okay;
    pop_word = 1'b0;
    case (s_axil_araddr[11:0])
      mmio_req_cnt_addr: rdata_n = S_AXIL_DATA_WIDTH'(word_cnt);
      mmio_req_addr: begin
        if (word_cnt != '0) begin
          pop_word = 1'b1;
          rdata_n  = half_r ? fifo_data[63:32] : fifo_data[31:0];
        end else begin
          rresp_n = e_axil_slverr;
        end
      end
      default: rresp_n = e_axil_decerr;
    endcase
  end

  assign pop_take = ar_fire & pop_word;

  // Registered R channel; data only changes on AR acceptance, so it holds
  // steady while the host stalls rready.
  always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
    if (!s_axil_aresetn) begin
      rvalid_r <= 1'b0;
      rdata_r  <= '0;
      rresp_r  <= e_axil_okay;
      half_r   <= 1'b0;
    end else begin
      if (ar_fire) begin
        rvalid_r <= 1'b1;
        rdata_r  <= rdata_n;
        rresp_r  <= rresp_n;
      end else if (s_axil_rready) begin
        rvalid_r <= 1'b0;
      end
      if (pop_take) half_r <= ~half_r;
    end
  end

  assign s_axil_rvalid = rvalid_r;
  assign s_axil_rdata  = rdata_r;
  assign s_axil_rresp  = rresp_r;

  assign s_axil_bvalid  = (w_state_r == e_w_resp);
  assign s_axil_bresp   = e_axil_slverr;
  assign s_axil_awready = run & ~aw_held_r & ~s_axil_bvalid;
  assign s_axil_wready  = run & ~w_held_r & ~s_axil_bvalid;
  assign aw_fire        = s_axil_awvalid & s_axil_awready;
  assign w_fire         = s_axil_wvalid & s_axil_wready;

  // Write sub-FSM and held-beat flags.
  always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
    if (!s_axil_aresetn) begin
      w_state_r <= e_w_collect;
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
    end else begin
      w_state_r <= w_state_n;
      aw_held_r <= aw_held_n;
      w_held_r  <= w_held_n;
    end
  end

  // Collect both beats in any order, then answer once with SLVERR.
  always_comb begin
    w_state_n = w_state_r;
    aw_held_n = aw_held_r;
    w_held_n  = w_held_r;
    case (w_state_r)
      e_w_collect: begin
        if (aw_fire) aw_held_n = 1'b1;
        if (w_fire)  w_held_n  = 1'b1;
        if (aw_held_n & w_held_n) w_state_n = e_w_resp;
      end
      e_w_resp: begin
        if (s_axil_bready) begin
          w_state_n = e_w_collect;
          aw_held_n = 1'b0;
          w_held_n  = 1'b0;
        end
      end
      default: w_state_n = e_w_collect;
    endcase
  end

endmodule

// File: tb/tb_bp_axil_mmio_req_buffer.sv
// Directed bench for the BP MMIO request buffer.
`timescale 1ns/1ps
module tb_bp_axil_mmio_req_buffer;

  logic        s_axil_aclk = 1'b0;
  logic        s_axil_aresetn = 1'b0;
  logic        mmio_v_i = 1'b0;
  logic [31:0] mmio_addr_i = '0;
  logic [31:0] mmio_data_i = '0;
  logic        mmio_ready_and_o;
  logic [63:0] s_axil_araddr = '0;
  logic        s_axil_arvalid = 1'b0;
  logic        s_axil_arready;
  logic [2:0]  s_axil_arprot = '0;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready = 1'b0;
  logic [63:0] s_axil_awaddr = '0;
  logic        s_axil_awvalid = 1'b0;
  logic        s_axil_awready;
  logic [2:0]  s_axil_awprot = '0;
  logic [31:0] s_axil_wdata = '0;
  logic [3:0]  s_axil_wstrb = '0;
  logic        s_axil_wvalid = 1'b0;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 s_axil_aclk = ~s_axil_aclk;

  bp_axil_mmio_req_buffer #(
    .S_AXIL_ADDR_WIDTH(64),
    .S_AXIL_DATA_WIDTH(32),
    .els_p(32)
  ) dut (
    .s_axil_aclk(s_axil_aclk), .s_axil_aresetn(s_axil_aresetn),
    .mmio_v_i(mmio_v_i), .mmio_addr_i(mmio_addr_i), .mmio_data_i(mmio_data_i),
    .mmio_ready_and_o(mmio_ready_and_o),
    .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready), .s_axil_arprot(s_axil_arprot),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid),
    .s_axil_awready(s_axil_awready), .s_axil_awprot(s_axil_awprot),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready)
  );

  // Stimulus: one AXI-Lite read, returning the captured R beat.
  task automatic axil_read(input logic [63:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
    int n;
    @(negedge s_axil_aclk);
    s_axil_araddr  = addr;
    s_axil_arvalid = 1'b1;
    s_axil_rready  = 1'b1;
    n = 0;
    while (!s_axil_arready && n < 50) begin @(negedge s_axil_aclk); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL ar_timeout addr=%h arready never rose", addr);
    end
    @(negedge s_axil_aclk);
    s_axil_arvalid = 1'b0;
    n = 0;
    while (!s_axil_rvalid && n < 50) begin @(negedge s_axil_aclk); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL r_timeout addr=%h rvalid never rose", addr);
    end
    data = s_axil_rdata;
    resp = s_axil_rresp;
  endtask

  // Stimulus: push one pair on the BP side.
  task automatic push_pair(input logic [31:0] a, input logic [31:0] d);
    int n;
    @(negedge s_axil_aclk);
    mmio_v_i = 1'b1; mmio_addr_i = a; mmio_data_i = d;
    n = 0;
    while (!mmio_ready_and_o && n < 50) begin @(negedge s_axil_aclk); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL push_timeout addr=%h ready never rose", a);
    end
    @(negedge s_axil_aclk);
    mmio_v_i = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({s_axil_rvalid, s_axil_bvalid, s_axil_arready, s_axil_awready,
         s_axil_wready, mmio_ready_and_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b want=000000", {s_axil_rvalid, s_axil_bvalid,
               s_axil_arready, s_axil_awready, s_axil_wready, mmio_ready_and_o});
    end
    checks++;
    if ({s_axil_rdata, s_axil_rresp} !== 34'h0) begin
      errors++;
      $display("FAIL reset_data got=%h want=0", {s_axil_rdata, s_axil_rresp});
    end
    @(negedge s_axil_aclk);
    s_axil_aresetn = 1'b1;
    #1;
    checks++;
    if ({s_axil_arready, s_axil_awready, mmio_ready_and_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_first_cycle got=%b want=000",
               {s_axil_arready, s_axil_awready, mmio_ready_and_o});
    end
    @(negedge s_axil_aclk);
    checks++;
    if ({s_axil_arready, s_axil_awready, s_axil_wready, mmio_ready_and_o} !== 4'b1111) begin
      errors++;
      $display("FAIL run_ready got=%b want=1111",
               {s_axil_arready, s_axil_awready, s_axil_wready, mmio_ready_and_o});
    end
  endtask

  task automatic test_empty_poll();
    logic [31:0] d; logic [1:0] r;
    axil_read(64'h8, d, r);
    checks++;
    if ({d, r} !== {32'h0, 2'b00}) begin
      errors++; $display("FAIL empty_cnt got=%h/%b want=0/00", d, r);
    end
    axil_read(64'hC, d, r);
    checks++;
    if ({d, r} !== {32'h0, 2'b10}) begin
      errors++; $display("FAIL empty_pop got=%h/%b want=0/10", d, r);
    end
  endtask

  task automatic test_one_push();
    logic [31:0] d; logic [1:0] r;
    push_pair(32'h0010_1000, 32'h41);
    axil_read(64'h8, d, r);
    checks++;
    if ({d, r} !== {32'd2, 2'b00}) begin errors++; $display("FAIL one_cnt2 got=%h/%b want=2/00", d, r); end
    axil_read(64'hC, d, r);
    checks++;
    if ({d, r} !== {32'h0010_1000, 2'b00}) begin errors++; $display("FAIL one_addr got=%h/%b want=00101000/00", d, r); end
    axil_read(64'h8, d, r);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL one_cnt1 got=%0d want=1", d); end
    axil_read(64'hC, d, r);
    checks++;
    if ({d, r} !== {32'h41, 2'b00}) begin errors++; $display("FAIL one_data got=%h/%b want=41/00", d, r); end
    axil_read(64'h8, d, r);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL one_cnt0 got=%0d want=0", d); end
  endtask

  task automatic test_fill();
    logic [31:0] d; logic [1:0] r;
    for (int i = 0; i < 16; i++) push_pair(32'h8000_0000 + 32'(i * 8), 32'hD000_0000 + 32'(i));
    checks++;
    if (mmio_ready_and_o !== 1'b0) begin errors++; $display("FAIL full_ready got=%b want=0", mmio_ready_and_o); end
    axil_read(64'h8, d, r);
    checks++;
    if (d !== 32'd32) begin errors++; $display("FAIL full_cnt got=%0d want=32", d); end
    axil_read(64'hC, d, r);
    checks++;
    if (d !== 32'h8000_0000) begin errors++; $display("FAIL fill_addr0 got=%h want=80000000", d); end
    checks++;
    if (mmio_ready_and_o !== 1'b0) begin errors++; $display("FAIL half_pop_ready got=%b want=0", mmio_ready_and_o); end
    axil_read(64'hC, d, r);
    checks++;
    if (d !== 32'hD000_0000) begin errors++; $display("FAIL fill_data0 got=%h want=d0000000", d); end
    checks++;
    if (mmio_ready_and_o !== 1'b1) begin errors++; $display("FAIL ready_return got=%b want=1", mmio_ready_and_o); end
    push_pair(32'h8000_0080, 32'hD000_0010);
    for (int i = 1; i <= 16; i++) begin
      axil_read(64'hC, d, r);
      checks++;
      if ({d, r} !== {32'h8000_0000 + 32'(i * 8), 2'b00}) begin
        errors++; $display("FAIL drain_addr[%0d] got=%h/%b want=%h/00", i, d, r, 32'h8000_0000 + 32'(i * 8));
      end
      axil_read(64'hC, d, r);
      checks++;
      if ({d, r} !== {32'hD000_0000 + 32'(i), 2'b00}) begin
        errors++; $display("FAIL drain_data[%0d] got=%h/%b want=%h/00", i, d, r, 32'hD000_0000 + 32'(i));
      end
    end
    axil_read(64'h8, d, r);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL drained_cnt got=%0d want=0", d); end
  endtask

  task automatic test_simul_push_pop();
    logic [31:0] d; logic [1:0] r;
    push_pair(32'hA000_0000, 32'hA1);
    axil_read(64'hC, d, r);
    checks++;
    if (d !== 32'hA000_0000) begin errors++; $display("FAIL simul_addrA got=%h want=a0000000", d); end
    @(negedge s_axil_aclk);
    mmio_v_i = 1'b1; mmio_addr_i = 32'hB000_0000; mmio_data_i = 32'hB1;
    s_axil_araddr = 64'hC; s_axil_arvalid = 1'b1; s_axil_rready = 1'b1;
    checks++;
    if ({mmio_ready_and_o, s_axil_arready} !== 2'b11) begin
      errors++; $display("FAIL simul_ready got=%b want=11", {mmio_ready_and_o, s_axil_arready});
    end
    @(negedge s_axil_aclk);
    mmio_v_i = 1'b0; s_axil_arvalid = 1'b0;
    checks++;
    if ({s_axil_rvalid, s_axil_rdata} !== {1'b1, 32'hA1}) begin
      errors++; $display("FAIL simul_dataA got=%b/%h want=1/a1", s_axil_rvalid, s_axil_rdata);
    end
    axil_read(64'h8, d, r);
    checks++;
    if (d !== 32'd2) begin errors++; $display("FAIL simul_cnt got=%0d want=2", d); end
    axil_read(64'hC, d, r);
    checks++;
    if (d !== 32'hB000_0000) begin errors++; $display("FAIL simul_addrB got=%h want=b0000000", d); end
    axil_read(64'hC, d, r);
    checks++;
    if (d !== 32'hB1) begin errors++; $display("FAIL simul_dataB got=%h want=b1", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [1:0] r;
    push_pair(32'hC000_0000, 32'hC1);
    push_pair(32'hC000_0004, 32'hC2);
    @(negedge s_axil_aclk);
    s_axil_araddr = 64'hC; s_axil_arvalid = 1'b1; s_axil_rready = 1'b0;
    checks++;
    if (s_axil_arready !== 1'b1) begin errors++; $display("FAIL b2b_arready_idle got=%b want=1", s_axil_arready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge s_axil_aclk);
      checks++;
      if ({s_axil_arready, s_axil_rvalid, s_axil_rdata} !== {2'b01, 32'hC000_0000}) begin
        errors++; $display("FAIL b2b_stall[%0d] got=%b/%b/%h want=0/1/c0000000",
                           i, s_axil_arready, s_axil_rvalid, s_axil_rdata);
      end
    end
    s_axil_rready = 1'b1;
    #1;
    checks++;
    if (s_axil_arready !== 1'b1) begin errors++; $display("FAIL b2b_arready_release got=%b want=1", s_axil_arready); end
    @(negedge s_axil_aclk);
    checks++;
    if ({s_axil_rvalid, s_axil_rdata} !== {1'b1, 32'hC1}) begin
      errors++; $display("FAIL b2b_second got=%b/%h want=1/c1", s_axil_rvalid, s_axil_rdata);
    end
    @(negedge s_axil_aclk);
    s_axil_arvalid = 1'b0;
    checks++;
    if ({s_axil_rvalid, s_axil_rdata} !== {1'b1, 32'hC000_0004}) begin
      errors++; $display("FAIL b2b_third got=%b/%h want=1/c0000004", s_axil_rvalid, s_axil_rdata);
    end
    @(negedge s_axil_aclk);
    checks++;
    if (s_axil_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_rvalid_clear got=%b want=0", s_axil_rvalid); end
    axil_read(64'h8, d, r);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL b2b_cnt got=%0d want=1", d); end
    axil_read(64'hC, d, r);
    checks++;
    if (d !== 32'hC2) begin errors++; $display("FAIL b2b_last got=%h want=c2", d); end
  endtask

  task automatic test_write();
    logic [31:0] d; logic [1:0] r;
    @(negedge s_axil_aclk);
    s_axil_awaddr = 64'h8; s_axil_awvalid = 1'b1;
    checks++;
    if ({s_axil_awready, s_axil_wready} !== 2'b11) begin
      errors++; $display("FAIL wr_idle_ready got=%b want=11", {s_axil_awready, s_axil_wready});
    end
    @(negedge s_axil_aclk);
    s_axil_awvalid = 1'b0;
    checks++;
    if ({s_axil_awready, s_axil_wready, s_axil_bvalid} !== 3'b010) begin
      errors++; $display("FAIL wr_aw_held got=%b want=010", {s_axil_awready, s_axil_wready, s_axil_bvalid});
    end
    @(negedge s_axil_aclk);
    s_axil_wdata = 32'hDEAD_BEEF; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    checks++;
    if ({s_axil_wready, s_axil_bvalid} !== 2'b10) begin
      errors++; $display("FAIL wr_w_ready got=%b want=10", {s_axil_wready, s_axil_bvalid});
    end
    @(negedge s_axil_aclk);
    s_axil_wvalid = 1'b0;
    checks++;
    if ({s_axil_bvalid, s_axil_bresp, s_axil_awready, s_axil_wready} !== 5'b11000) begin
      errors++; $display("FAIL wr_bresp got=%b want=11000",
                         {s_axil_bvalid, s_axil_bresp, s_axil_awready, s_axil_wready});
    end
    @(negedge s_axil_aclk);
    checks++;
    if (s_axil_bvalid !== 1'b1) begin errors++; $display("FAIL wr_bhold got=%b want=1", s_axil_bvalid); end
    s_axil_bready = 1'b1;
    @(negedge s_axil_aclk);
    s_axil_bready = 1'b0;
    checks++;
    if ({s_axil_bvalid, s_axil_awready, s_axil_wready} !== 3'b011) begin
      errors++; $display("FAIL wr_bclear got=%b want=011", {s_axil_bvalid, s_axil_awready, s_axil_wready});
    end
    @(negedge s_axil_aclk);
    checks++;
    if (s_axil_bvalid !== 1'b0) begin errors++; $display("FAIL wr_single_b got=%b want=0", s_axil_bvalid); end
    axil_read(64'h8, d, r);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL wr_fifo_unchanged got=%0d want=0", d); end
  endtask

  task automatic test_decode();
    logic [31:0] d; logic [1:0] r;
    axil_read(64'h10, d, r);
    checks++;
    if ({d, r} !== {32'h0, 2'b11}) begin errors++; $display("FAIL decerr got=%h/%b want=0/11", d, r); end
    push_pair(32'hE000_0000, 32'hE1);
    axil_read(64'h1234_5678_9ABC_D008, d, r);
    checks++;
    if ({d, r} !== {32'd2, 2'b00}) begin errors++; $display("FAIL upper_bits_cnt got=%h/%b want=2/00", d, r); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r;
    push_pair(32'hF000_0000, 32'hF1);
    axil_read(64'hC, d, r);
    checks++;
    if (d !== 32'hE000_0000) begin errors++; $display("FAIL mid_first got=%h want=e0000000", d); end
    @(negedge s_axil_aclk);
    s_axil_araddr = 64'hC; s_axil_arvalid = 1'b1; s_axil_rready = 1'b0;
    @(negedge s_axil_aclk);
    s_axil_arvalid = 1'b0;
    #1 s_axil_aresetn = 1'b0;
    #1;
    checks++;
    if ({s_axil_rvalid, s_axil_bvalid, s_axil_arready, s_axil_awready, s_axil_wready,
         mmio_ready_and_o, s_axil_rdata, s_axil_rresp} !== 40'h0) begin
      errors++; $display("FAIL mid_reset_outputs got=%b%b%b%b%b%b/%h/%b want=all zero",
                         s_axil_rvalid, s_axil_bvalid, s_axil_arready, s_axil_awready,
                         s_axil_wready, mmio_ready_and_o, s_axil_rdata, s_axil_rresp);
    end
    @(negedge s_axil_aclk);
    s_axil_aresetn = 1'b1;
    @(negedge s_axil_aclk);
    axil_read(64'h8, d, r);
    checks++;
    if ({d, r} !== {32'h0, 2'b00}) begin errors++; $display("FAIL mid_cnt got=%h/%b want=0/00", d, r); end
    axil_read(64'hC, d, r);
    checks++;
    if ({d, r} !== {32'h0, 2'b10}) begin errors++; $display("FAIL mid_pop got=%h/%b want=0/10", d, r); end
  endtask

  initial begin
    test_reset();
    test_empty_poll();
    test_one_push();
    test_fill();
    test_simul_push_pop();
    test_back_to_back();
    test_write();
    test_decode();
    test_reset_mid();
    @(negedge s_axil_aclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
